// File: rtl/mul8_rr_sched.sv
// Round-robin scheduler sharing one external 8x8 array multiplier between two requesters.
// Optional grant/stall statistics are compiled in with MUL8_RR_SCHED_STATS_EN.
module mul8_rr_sched #(
    parameter int LAT = 2,
    parameter int CW  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        req1_ready,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_p,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [15:0] resp_prod,
    input  logic        resp_ready,
    output logic        busy
`ifdef MUL8_RR_SCHED_STATS_EN
    ,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1,
    output logic [15:0] stall_cnt
`endif
);

    // Handshakes: a transfer happens on the rising edge where valid && ready are both high.
    // Requesters hold a/b stable while valid is high; resp_* hold stable while resp_valid is high.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    logic          owner;
    logic          last_grant;
    logic [CW-1:0] cnt;
    logic          win0;
    logic          win1;

    // On contention the requester that was not granted last time wins.
    always_comb begin
        win0       = req0_valid && (!req1_valid || last_grant);
        win1       = req1_valid && (!req0_valid || !last_grant);
        req0_ready = (state == IDLE) && win0;
        req1_ready = (state == IDLE) && win1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            mul_a      <= 8'd0;
            mul_b      <= 8'd0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_prod  <= 16'd0;
            busy       <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win0 || win1) begin
                        mul_a      <= win0 ? req0_a : req1_a;
                        mul_b      <= win0 ? req0_b : req1_b;
                        owner      <= win1;
                        last_grant <= win1;
                        cnt        <= CW'(LAT - 1);
                        state      <= SETTLE;
                        busy       <= 1'b1;
                    end
                end
                SETTLE: begin
                    // Operands have been stable for LAT cycles when the counter reaches zero.
                    if (cnt == '0) begin
                        resp_prod  <= mul_p;
                        resp_id    <= owner;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MUL8_RR_SCHED_STATS_EN
    // stall_cnt advances once per cycle in which any requester is left waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt0 <= 16'd0;
            grant_cnt1 <= 16'd0;
            stall_cnt  <= 16'd0;
        end else begin
            if (req0_valid && req0_ready) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (req1_valid && req1_ready) grant_cnt1 <= grant_cnt1 + 16'd1;
            if ((req0_valid && !req0_ready) || (req1_valid && !req1_ready))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
